// File: rtl/bomb_timer.sv
// Per-player bomb lifecycle: placement latch, fuse countdown, blast hold, placement cooldown.
// Optional chain detonation enabled by defining BOMB_CHAIN_DETONATE_EN.
module bomb_timer #(
  parameter int unsigned BLAST_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       place_req,
  input  logic [3:0] char_tx,
  input  logic [3:0] char_ty,
  input  logic [1:0] size_cfg,
  input  logic [9:0] delay_cfg,
  input  logic [9:0] cool_cfg,
  input  logic       ext_detonate,
  output logic [9:0] delay,
  output logic [9:0] cooldown,
  output logic       bomb_active,
  output logic [3:0] bomb_tx,
  output logic [3:0] bomb_ty,
  output logic       blast_active,
  output logic [1:0] blast_size,
  output logic       exploded
);

  localparam int unsigned CW = 10;
  localparam int unsigned TW = 4;
  localparam int unsigned SW = 2;
  localparam logic [CW-1:0] BLAST_CNT_INIT = CW'(BLAST_FRAMES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_BLAST = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] delay_q, delay_d;
  logic [CW-1:0] cooldown_q, cooldown_d;
  logic [CW-1:0] blast_cnt_q, blast_cnt_d;
  logic [TW-1:0] bomb_tx_q, bomb_tx_d;
  logic [TW-1:0] bomb_ty_q, bomb_ty_d;
  logic [SW-1:0] blast_size_q, blast_size_d;
  logic          exploded_q, exploded_d;
  logic          bomb_active_q, bomb_active_d;
  logic          blast_active_q, blast_active_d;
  logic          chain_c;

`ifdef BOMB_CHAIN_DETONATE_EN
  assign chain_c = ext_detonate;
`else
  logic unused_ext_detonate;
  assign unused_ext_detonate = ext_detonate;
  assign chain_c = 1'b0;
`endif

  // Next-state and counter update; placement loads override the same-cycle tick.
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    blast_cnt_d  = blast_cnt_q;
    bomb_tx_d    = bomb_tx_q;
    bomb_ty_d    = bomb_ty_q;
    blast_size_d = blast_size_q;
    exploded_d   = 1'b0;
    cooldown_d   = (frame_tick && (cooldown_q != '0)) ? cooldown_q - CW'(1) : cooldown_q;

    case (state_q)
      S_IDLE: begin
        if (place_req && (cooldown_q == '0)) begin
          state_d      = S_ARMED;
          bomb_tx_d    = char_tx;
          bomb_ty_d    = char_ty;
          blast_size_d = size_cfg;
          delay_d      = (delay_cfg == '0) ? CW'(1) : delay_cfg;
          cooldown_d   = cool_cfg;
        end
      end
      S_ARMED: begin
        if (chain_c || (frame_tick && (delay_q <= CW'(1)))) begin
          state_d     = S_BLAST;
          delay_d     = '0;
          blast_cnt_d = BLAST_CNT_INIT;
          exploded_d  = 1'b1;
        end else if (frame_tick) begin
          delay_d = delay_q - CW'(1);
        end
      end
      S_BLAST: begin
        if (frame_tick) begin
          if (blast_cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            blast_cnt_d = blast_cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        delay_d = '0;
      end
    endcase

    bomb_active_d  = (state_d == S_ARMED);
    blast_active_d = (state_d == S_BLAST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      delay_q        <= '0;
      cooldown_q     <= '0;
      blast_cnt_q    <= '0;
      bomb_tx_q      <= '0;
      bomb_ty_q      <= '0;
      blast_size_q   <= '0;
      exploded_q     <= 1'b0;
      bomb_active_q  <= 1'b0;
      blast_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      delay_q        <= delay_d;
      cooldown_q     <= cooldown_d;
      blast_cnt_q    <= blast_cnt_d;
      bomb_tx_q      <= bomb_tx_d;
      bomb_ty_q      <= bomb_ty_d;
      blast_size_q   <= blast_size_d;
      exploded_q     <= exploded_d;
      bomb_active_q  <= bomb_active_d;
      blast_active_q <= blast_active_d;
    end
  end

  assign delay        = delay_q;
  assign cooldown     = cooldown_q;
  assign bomb_active  = bomb_active_q;
  assign bomb_tx      = bomb_tx_q;
  assign bomb_ty      = bomb_ty_q;
  assign blast_active = blast_active_q;
  assign blast_size   = blast_size_q;
  assign exploded     = exploded_q;

endmodule
